// File: rtl/iiitb_brg.sv
// Baud-rate clock generator: divides clk by one of four selectable
// half-periods into a 50% duty square wave for UART bit timing.
module iiitb_brg #(
  parameter int CNT_W = 16,
  parameter int HALF0 = 5208,
  parameter int HALF1 = 2604,
  parameter int HALF2 = 1302,
  parameter int HALF3 = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  output logic       clkout
);

  // Terminal counts are H-1 so that H = 2^CNT_W still fits the counter.
  localparam logic [CNT_W-1:0] TERM0 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] TERM1 = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] TERM2 = CNT_W'(HALF2 - 1);
  localparam logic [CNT_W-1:0] TERM3 = CNT_W'(HALF3 - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  always_comb begin
    term = TERM0;
    unique case (sel)
      2'd0: term = TERM0;
      2'd1: term = TERM1;
      2'd2: term = TERM2;
      2'd3: term = TERM3;
    endcase
  end

  // >= lets a shrink to a shorter ratio end the current half at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      clkout <= 1'b0;
    end else if (cnt >= term) begin
      cnt    <= '0;
      clkout <= ~clkout;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iiitb_brg.sv
// Self-checking bench for iiitb_brg with half-periods 4/3/2/1:
// directed literal scenarios plus randomized sel/reset against a model.
module tb_iiitb_brg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel = 2'd0;
  logic       clkout;

  int tests = 0;
  int fails = 0;

  int half [4] = '{4, 3, 2, 1};

  // Model: cycles elapsed in current half-period and output level.
  int elapsed = 0;
  bit level = 1'b0;

  iiitb_brg #(
    .CNT_W(16),
    .HALF0(4),
    .HALF1(3),
    .HALF2(2),
    .HALF3(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .clkout(clkout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input logic [1:0] s);
    reset = r;
    sel   = s;
    @(posedge clk);
    if (r) begin
      elapsed = 0;
      level   = 1'b0;
    end else if (elapsed + 1 >= half[s]) begin
      // The half in progress has now lasted max(elapsed+1, H) cycles.
      elapsed = 0;
      level   = ~level;
    end else begin
      elapsed++;
    end
    #1;
    check("model_clkout", int'(clkout), int'(level));
    check("model_cnt", int'(dut.cnt), elapsed);
  endtask

  initial begin
    int p;
    int last_toggle;
    int edge_no;
    bit prev;

    // Reset hold with assorted sel values.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'(i + 1));
      check("reset_clkout", int'(clkout), 0);
      check("reset_cnt", int'(dut.cnt), 0);
    end

    // sel=0: rises on edge 4, falls on 8, rises on 12.
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, 2'd0);
      if (e == 3)  check("sel0_e3", int'(clkout), 0);
      if (e == 4)  check("sel0_rise4", int'(clkout), 1);
      if (e == 7)  check("sel0_e7", int'(clkout), 1);
      if (e == 8)  check("sel0_fall8", int'(clkout), 0);
      if (e == 12) check("sel0_rise12", int'(clkout), 1);
    end

    // Period sweep: measure toggle spacing for every sel over 5+ periods.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 2'(s));
      last_toggle = 0;
      prev = 1'b0;
      for (int e = 1; e <= 48; e++) begin
        step(1'b0, 2'(s));
        if (clkout != prev) begin
          p = e - last_toggle;
          check($sformatf("half_sel%0d", s), p, 4 - s);
          last_toggle = e;
          prev = clkout;
        end
      end
    end

    // Live shrink: sel=0 up to cnt=2, then sel=3 toggles every edge.
    step(1'b1, 2'd0);
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    check("shrink_cnt2", int'(dut.cnt), 2);
    step(1'b0, 2'd3);
    check("shrink_first", int'(clkout), 1);
    step(1'b0, 2'd3);
    check("shrink_second", int'(clkout), 0);
    step(1'b0, 2'd3);
    check("shrink_third", int'(clkout), 1);

    // Live shrink at cnt=3 (test plan case).
    step(1'b1, 2'd0);
    for (int e = 0; e < 3; e++) step(1'b0, 2'd0);
    check("shrink3_cnt", int'(dut.cnt), 3);
    step(1'b0, 2'd3);
    check("shrink3_tog", int'(clkout), 1);
    step(1'b0, 2'd3);
    check("shrink3_tog2", int'(clkout), 0);

    // Live grow: sel=3 toggles, then sel=0 stretches that half to 4.
    step(1'b1, 2'd3);
    step(1'b0, 2'd3);
    check("grow_start", int'(clkout), 1);
    for (int e = 2; e <= 13; e++) begin
      step(1'b0, 2'd0);
      if (e == 4)  check("grow_hold", int'(clkout), 1);
      if (e == 5)  check("grow_fall", int'(clkout), 0);
      if (e == 8)  check("grow_low", int'(clkout), 0);
      if (e == 9)  check("grow_rise", int'(clkout), 1);
      if (e == 13) check("grow_fall2", int'(clkout), 0);
    end

    // Mid-run reset while clkout=1 and cnt=2.
    step(1'b1, 2'd0);
    for (int e = 0; e < 6; e++) step(1'b0, 2'd0);
    check("mid_pre_clk", int'(clkout), 1);
    check("mid_pre_cnt", int'(dut.cnt), 2);
    step(1'b1, 2'd0);
    check("mid_reset", int'(clkout), 0);
    for (int e = 1; e <= 4; e++) begin
      step(1'b0, 2'd0);
      if (e == 3) check("mid_after3", int'(clkout), 0);
      if (e == 4) check("mid_rise4", int'(clkout), 1);
    end

    // Randomized sel changes and occasional resets against the model.
    edge_no = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, sel);
      edge_no++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
